fifo: RTL and testbench
=======================

FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter DataWidth, default 8, SHALL set the data word width in bits (>=1).
REQ-002 Parameter Depth, default 8, SHALL set the number of storage entries; it SHALL be a power of two >=2.
REQ-003 Port i_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Port i_rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of i_clk.
REQ-005 Port i_data  input  DataWidth  SHALL carry the write word.
REQ-006 Port i_write_en  input  1  SHALL request a write of i_data.
REQ-007 Port i_read_en  input  1  SHALL request a read of the oldest entry.
REQ-008 Port o_data  output  DataWidth  SHALL present the most recently read word.
REQ-009 Port o_full  output  1  SHALL be high when Depth entries are stored.
REQ-010 Port o_empty  output  1  SHALL be high when 0 entries are stored.

Function
REQ-011 The block SHALL be a synchronous first-in-first-out buffer with Depth x DataWidth storage.
REQ-012 Read and write pointers SHALL be $clog2(Depth)+1 bits wide, with the MSB used as a wrap bit.
REQ-013 Both pointers SHALL increment by one per accepted operation and wrap modulo 2*Depth.
REQ-014 o_empty SHALL be 1 when the pointers are fully equal.
REQ-015 o_full SHALL be 1 when the pointer MSBs differ and the low bits are equal.
REQ-016 Both flags SHALL be combinational decodes of the registered pointers, with no extra latency.
REQ-017 A write SHALL be accepted on an edge with i_write_en=1 and o_full=0: the entry at the write pointer is written and the write pointer advances.
REQ-018 A write with o_full=1 SHALL be discarded, leaving storage and pointers unchanged.
REQ-019 A read SHALL be accepted on an edge with i_read_en=1 and o_empty=0: o_data is loaded with the entry at the read pointer and the read pointer advances.
REQ-020 Read latency SHALL be one cycle: the word is valid on o_data after the accepting edge.
REQ-021 A read with o_empty=1 SHALL be ignored; o_data and the pointers SHALL hold.
REQ-022 o_data SHALL hold its value on all cycles without an accepted read.
REQ-023 With simultaneous read and write requests and the FIFO neither empty nor full, both SHALL be accepted and occupancy SHALL be unchanged.
REQ-024 With simultaneous requests when empty, only the write SHALL be accepted.
REQ-025 With simultaneous requests when full, only the read SHALL be accepted.
REQ-026 Data SHALL emerge in write order across any number of pointer wrap-arounds.

Reset
REQ-027 While i_rst_n=0 at a rising edge, both pointers SHALL clear to 0, giving o_empty=1 and o_full=0.
REQ-028 Reset SHALL also clear o_data to 0 and the error flags of REQ-031 to 0.
REQ-029 Reset SHALL take priority over any simultaneous read or write.
REQ-030 Storage contents SHALL NOT be reset; after reset, previously stored data SHALL never be readable.

Configuration
REQ-031 With macro FIFO_ERR_FLAGS_EN defined, the block SHALL add two outputs, o_overflow and o_underflow (each 1 bit).
REQ-032 o_overflow SHALL set on a discarded write, o_underflow SHALL set on an ignored read, and both SHALL be sticky until reset.
REQ-033 Without FIFO_ERR_FLAGS_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Reset test: hold i_rst_n=0 for 1 edge, release, then pulse it low again -> o_empty=1, o_full=0, o_data=8'h00 after each reset.
REQ-035 Fill test: write 24,81,09,63,0D,8D,65,12 (hex) as single-cycle pulses -> o_empty=0 after the first write and o_full=1 after the eighth.
REQ-036 Drain test: 8 read pulses -> o_data shows 24,81,09,63,0D,8D,65,12 in order, o_full=0 after the first read, o_empty=1 after the eighth.
REQ-037 Boundary test: write 0xAA while full, then read while empty -> data is unchanged and the pointers do not move; with FIFO_ERR_FLAGS_EN, o_overflow=1 and o_underflow=1.
REQ-038 Wrap and concurrency test: write/read 5 words, then write 8 words with simultaneous read+write on the 4th -> order is preserved and o_full asserts only at occupancy 8.
REQ-039 Mid-operation reset test: with 3 words stored, assert i_rst_n=0 for one edge -> o_empty=1, o_data=0, and the next read is ignored.

Source files
------------

// File: rtl/fifo.sv
// ----------------------------------------------------------------------------
// fifo -- synchronous first-in-first-out buffer, Depth x DataWidth storage.
//
// Parameters
//   DataWidth   data word width in bits (>= 1)
//   Depth       number of entries (power of two, >= 2)
//
// Ports
//   i_clk        single clock, all state updates on its rising edge
//   i_rst_n      synchronous active-low reset
//   i_data       write word
//   i_write_en   write request (discarded while full)
//   i_read_en    read request (ignored while empty)
//   o_data       most recently read word, one cycle after the accepting edge
//   o_full       Depth entries stored
//   o_empty      no entries stored
//   o_overflow   sticky: a write was discarded   (FIFO_ERR_FLAGS_EN only)
//   o_underflow  sticky: a read was ignored      (FIFO_ERR_FLAGS_EN only)
//
// Build option
//   FIFO_ERR_FLAGS_EN  when defined, adds the sticky o_overflow/o_underflow
//                      outputs; otherwise those ports and their logic are
//                      absent and all other behaviour is identical.
// ----------------------------------------------------------------------------
module fifo #(
    parameter int DataWidth = 8,
    parameter int Depth     = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DataWidth-1:0] i_data,
    input  logic                 i_write_en,
    input  logic                 i_read_en,
    output logic [DataWidth-1:0] o_data,
    output logic                 o_full,
    output logic                 o_empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                 o_overflow,
    output logic                 o_underflow
`endif
);

    localparam int AW = $clog2(Depth);

    // Pointers carry one extra MSB as a wrap bit so full and empty can be
    // told apart when the index bits coincide.
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [DataWidth-1:0] rd_data_q, rd_data_d;
    logic [DataWidth-1:0] mem_q [Depth];

    logic full;
    logic empty;
    logic wr_accept;
    logic rd_accept;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Acceptance uses the flags of the current occupancy, so a simultaneous
    // request pair on a full FIFO only reads and on an empty FIFO only writes.
    assign wr_accept = i_write_en && !full;
    assign rd_accept = i_read_en && !empty;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (rd_accept) begin
            rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage is never cleared; clearing the pointers already makes old
    // contents unreachable. Writes are blocked while reset is asserted.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && wr_accept) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

    assign o_data  = rd_data_q;
    assign o_full  = full;
    assign o_empty = empty;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  || (i_write_en && full);
        underflow_d = underflow_q || (i_read_en && empty);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo.sv
// ----------------------------------------------------------------------------
// tb_fifo -- directed, scoreboard-checked bench for fifo (DataWidth=8,
// Depth=8). The stimulus keeps a reference queue of stored words and pushes
// the word each accepted read should return onto an expected queue; a
// separate monitor pops and compares whenever the DUT accepts a read.
// ----------------------------------------------------------------------------
module tb_fifo;

    localparam int DW = 8;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          i_write_en = 1'b0;
    logic          i_read_en = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_full;
    logic          o_empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic          o_overflow;
    logic          o_underflow;
    logic          exp_ovf = 1'b0;
    logic          exp_unf = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    logic          rd_fire = 1'b0;

    fifo #(.DataWidth(DW), .Depth(DP)) dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .i_data     (i_data),
        .i_write_en (i_write_en),
        .i_read_en  (i_read_en),
        .o_data     (o_data),
        .o_full     (o_full),
        .o_empty    (o_empty)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .o_overflow (o_overflow),
        .o_underflow(o_underflow)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: a read handshake seen at the edge means o_data is presented
    // half a cycle later and must match the oldest expected word.
    always @(posedge clk) begin
        rd_fire <= i_rst_n && i_read_en && !o_empty;
    end

    always @(negedge clk) begin
        if (rd_fire) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd_data_unexpected: got %02h, required no read", o_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (o_data !== e) begin
                    miscompares++;
                    $display("FAIL rd_data: got %02h, required %02h", o_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_empty"}, 32'(o_empty), 32'(model_q.size() == 0));
        chk({tag, "_full"},  32'(o_full),  32'(model_q.size() == DP));
`ifdef FIFO_ERR_FLAGS_EN
        chk({tag, "_ovf"}, 32'(o_overflow),  32'(exp_ovf));
        chk({tag, "_unf"}, 32'(o_underflow), 32'(exp_unf));
`endif
    endtask

    // One clock of stimulus; the reference queue decides what is accepted.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        logic wr_ok, rd_ok;
        wr_ok = w && (model_q.size() < DP);
        rd_ok = r && (model_q.size() > 0);
`ifdef FIFO_ERR_FLAGS_EN
        if (w && !wr_ok) exp_ovf = 1'b1;
        if (r && !rd_ok) exp_unf = 1'b1;
`endif
        if (rd_ok) exp_q.push_back(model_q.pop_front());
        if (wr_ok) model_q.push_back(d);
        i_write_en = w;
        i_data     = d;
        i_read_en  = r;
        @(posedge clk);
        #1;
        i_write_en = 1'b0;
        i_read_en  = 1'b0;
    endtask

    // Reset for one edge, optionally with read and write requests pending.
    task automatic do_reset(input logic w, input logic r);
        i_rst_n    = 1'b0;
        i_write_en = w;
        i_data     = 8'h5A;
        i_read_en  = r;
        @(posedge clk);
        #1;
        i_rst_n    = 1'b1;
        i_write_en = 1'b0;
        i_read_en  = 1'b0;
        model_q.delete();
`ifdef FIFO_ERR_FLAGS_EN
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
`endif
        chk("rst_empty", 32'(o_empty), 32'd1);
        chk("rst_full",  32'(o_full),  32'd0);
        chk("rst_data",  32'(o_data),  32'h00);
`ifdef FIFO_ERR_FLAGS_EN
        chk("rst_ovf", 32'(o_overflow),  32'd0);
        chk("rst_unf", 32'(o_underflow), 32'd0);
`endif
    endtask

    logic [DW-1:0] fill_vec [8] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};

    initial begin
        // Reset test: initial reset, release, pulse again.
        do_reset(1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        do_reset(1'b0, 1'b0);

        // Fill test.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, fill_vec[i], 1'b0);
            chk_flags("fill");
        end
        chk("fill_full_at_8", 32'(o_full), 32'd1);

        // Boundary: write while full is discarded.
        step(1'b1, 8'hAA, 1'b0);
        chk_flags("wr_full");
        chk("wr_full_data_hold", 32'(o_data), 32'h00);

        // Drain test; the monitor checks 24,81,09,63,0D,8D,65,12 in order.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk_flags("drain");
        end
        chk("drain_last", 32'(o_data), 32'h12);

        // Boundary: read while empty is ignored, o_data holds.
        step(1'b0, 8'h00, 1'b1);
        chk_flags("rd_empty");
        chk("rd_empty_data_hold", 32'(o_data), 32'h12);

        // Wrap and concurrency: 5 in / 5 out, then 8 writes with a
        // simultaneous read on the 4th, then one more write to reach full.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
        chk_flags("wrap5");
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'hC0 + i), (i == 3));
            chk_flags("wrap8");
        end
        chk("occ7_not_full", 32'(o_full), 32'd0);
        step(1'b1, 8'hC8, 1'b0);
        chk("occ8_full", 32'(o_full), 32'd1);
        // Simultaneous read+write while full: only the read is accepted.
        step(1'b1, 8'hEE, 1'b1);
        chk_flags("rw_full");
        // Simultaneous read+write in the middle keeps occupancy.
        step(1'b1, 8'hC9, 1'b1);
        chk_flags("rw_mid");
        while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1);
        chk_flags("wrap_drain");
        // Simultaneous read+write while empty: only the write is accepted.
        step(1'b1, 8'h77, 1'b1);
        chk_flags("rw_empty");
        step(1'b0, 8'h00, 1'b1);

        // Mid-operation reset with 3 stored words and a pending write.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
        do_reset(1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk_flags("post_rst_read");
        chk("post_rst_read_data", 32'(o_data), 32'h00);

        // Let the monitor settle, then anything still expected was never seen.
        repeat (2) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rd_missing: got no read, required %02h", exp_q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
